// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder on the data-memory bus: output port, synchronized
// input port with sticky rising-edge flags, a down-counting timer and a status word.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0040,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        IOSelect,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        EdgePending
);

  localparam int SyncWidth = SYNC_STAGES * 8;

  localparam logic [2:0] OffPortOut = 3'd0;
  localparam logic [2:0] OffPortIn  = 3'd1;
  localparam logic [2:0] OffInEdge  = 3'd2;
  localparam logic [2:0] OffTimer   = 3'd3;
  localparam logic [2:0] OffStatus  = 3'd4;

  logic                 hit;
  logic [2:0]           wordSel;
  logic                 wrPortOut;
  logic                 wrInEdge;
  logic                 wrTimer;
  logic                 wrStatus;

  logic [SyncWidth-1:0] syncChain;
  logic [7:0]           portInSync;
  logic [7:0]           portInPrev;
  logic [7:0]           riseEvent;

  logic [7:0]           inEdge;
  logic [7:0]           inEdgeNext;
  logic [31:0]          timerCount;
  logic [31:0]          timerNext;
  logic                 done;
  logic                 doneNext;
  logic                 doneSet;
  logic [31:0]          portOutNext;
  logic                 edgePendingNext;
  logic [31:0]          readMux;

  // Window hit requires matching the 32-byte block and a word-aligned address.
  assign hit        = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
  assign IOSelect   = hit;
  assign wordSel    = Address[4:2];
  assign portInSync = syncChain[SyncWidth-1 -: 8];

  // Store decode: one write enable per writable register.
  always_comb begin
    wrPortOut = 1'b0;
    wrInEdge  = 1'b0;
    wrTimer   = 1'b0;
    wrStatus  = 1'b0;
    if (hit && MemWrite) begin
      case (wordSel)
        OffPortOut: wrPortOut = 1'b1;
        OffInEdge:  wrInEdge  = 1'b1;
        OffTimer:   wrTimer   = 1'b1;
        OffStatus:  wrStatus  = 1'b1;
        default: begin
          wrPortOut = 1'b0;
          wrInEdge  = 1'b0;
          wrTimer   = 1'b0;
          wrStatus  = 1'b0;
        end
      endcase
    end else begin
      wrPortOut = 1'b0;
      wrInEdge  = 1'b0;
      wrTimer   = 1'b0;
      wrStatus  = 1'b0;
    end
  end

  // Next-state logic; hardware set events take priority over W1C clears.
  always_comb begin
    riseEvent       = portInSync & ~portInPrev;
    inEdgeNext      = inEdge | riseEvent;
    timerNext       = timerCount;
    doneSet         = 1'b0;
    doneNext        = done;
    portOutNext     = PortOut;
    edgePendingNext = |inEdge;

    if (wrInEdge) begin
      inEdgeNext = (inEdge & ~WriteData[7:0]) | riseEvent;
    end else begin
      inEdgeNext = inEdge | riseEvent;
    end

    // A load overrides the decrement, so a load while at 1 never raises DONE.
    if (wrTimer) begin
      timerNext = WriteData;
      doneSet   = 1'b0;
    end else if (timerCount != 32'd0) begin
      timerNext = timerCount - 32'd1;
      doneSet   = (timerCount == 32'd1);
    end else begin
      timerNext = timerCount;
      doneSet   = 1'b0;
    end

    if (doneSet) begin
      doneNext = 1'b1;
    end else if (wrStatus && WriteData[0]) begin
      doneNext = 1'b0;
    end else begin
      doneNext = done;
    end

    if (wrPortOut) begin
      portOutNext = WriteData;
    end else begin
      portOutNext = PortOut;
    end
  end

  // Load data mux; reads come from current state so a same-cycle store shows the old value.
  always_comb begin
    readMux = 32'h0;
    case (wordSel)
      OffPortOut: readMux = PortOut;
      OffPortIn:  readMux = {24'h0, portInSync};
      OffInEdge:  readMux = {24'h0, inEdge};
      OffTimer:   readMux = timerCount;
      OffStatus:  readMux = {30'h0, EdgePending, done};
      default:    readMux = 32'h0;
    endcase
    if (hit && MemRead) begin
      ReadData = readMux;
    end else begin
      ReadData = 32'h0;
    end
  end

  // State registers, including the input synchronizer chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncChain   <= '0;
      portInPrev  <= 8'h00;
      inEdge      <= 8'h00;
      timerCount  <= 32'h0;
      done        <= 1'b0;
      PortOut     <= 32'h0;
      EdgePending <= 1'b0;
    end else begin
      syncChain   <= {syncChain[SyncWidth-9:0], PortIn};
      portInPrev  <= portInSync;
      inEdge      <= inEdgeNext;
      timerCount  <= timerNext;
      done        <= doneNext;
      PortOut     <= portOutNext;
      EdgePending <= edgePendingNext;
    end
  end

endmodule

// File: doc/mmio_port_responder.md
# mmio_port_responder

Memory-mapped I/O responder on the processor's data-memory bus, sitting beside the data RAM. It answers the same load/store interface the core drives (Address, WriteData, MemWrite, MemRead), exposing five word registers:
- a latched 32-bit output port
- a synchronized 8-bit input port
- sticky input edge flags
- a down-counting timer
- a status word

The core's load-data path selects this block's ReadData whenever IOSelect is high.

## Interface
Parameters:
- BASE_ADDR, 32'h1001_0040, byte base of the 8-word window; must be 32-byte aligned
- SYNC_STAGES, 2, PortIn synchronizer depth (≥2)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears all state
- Address  input  32  byte address from ALU result
- WriteData  input  32  store data (rt value)
- MemWrite  input  1  store strobe, sampled at clk rising edge
- MemRead  input  1  load strobe
- ReadData  output  32  load data, combinational
- IOSelect  output  1  combinational hit: address is inside the window and word-aligned
- PortIn  input  8  asynchronous external pins
- PortOut  output  32  registered output port
- EdgePending  output  1  OR of all IN_EDGE flags, registered

## Operation
- Hit: Address[31:5]==BASE_ADDR[31:5] and Address[1:0]==2'b00. Misaligned or out-of-window addresses give IOSelect=0 and are ignored.
- Offsets:
  - 0x00 PORT_OUT RW: store updates PortOut.
  - 0x04 PORT_IN RO: {24'b0, synchronized PortIn}.
  - 0x08 IN_EDGE R/W1C: bit i sets on a 0→1 transition of synchronized PortIn[i]; a store clears the bits where WriteData[i]=1 (WriteData[31:8] ignored).
  - 0x0C TIMER RW: store loads the counter. The counter decrements by 1 each cycle while nonzero, and holds at 0.
  - 0x10 STATUS: bit0 DONE (W1C), bit1 = EdgePending (RO), other bits read 0.
  - 0x14–0x1C: read 0, stores ignored.
- DONE sets on the cycle the counter transitions 1→0. Loading TIMER with 0 does not set DONE. A TIMER load during counting overrides the decrement.
- ReadData = register value when IOSelect && MemRead, else 32'h0.
- MemWrite && MemRead both high: the write is performed; ReadData shows the pre-write value.
- Stores to RO offsets: no effect.
- Simultaneous events:
  - edge set and W1C clear on the same IN_EDGE bit in the same cycle: set wins (bit = 1)
  - DONE set and W1C clear in the same cycle: set wins
- Counter wrap: none; 32-bit unsigned, decrement only when nonzero.

## Timing
- Reset values: PortOut=0, IN_EDGE=0, TIMER=0, DONE=0, EdgePending=0, synchronizer flops=0. ReadData and IOSelect are combinational from inputs and state.
- Read latency: 0 cycles (same-cycle combinational). Required by the single-cycle core.
- Write latency: a register updates at the rising edge ending the store cycle; the new value is visible to a load in the next cycle.
- PortIn → PORT_IN: a pin change stable before edge k appears in PORT_IN after edge k+SYNC_STAGES-1 (2 edges with the default).
- PortIn → IN_EDGE: the flag is set one edge after the PORT_IN change. EdgePending follows one edge later.
- Timer: after a store of N≥1 at edge 0, TIMER reads N-1 after edge 1 and 0 after edge N. DONE=1 after edge N.
- Reset asserted mid-count or mid-synchronization: all state clears immediately (asynchronously). Counting resumes only after a new TIMER store.

## Test plan
- Reset then load each offset 0x00–0x1C → all read 0. IOSelect=1 for BASE+0x00..0x1C and 0 for BASE+0x20 and BASE+0x02.
- Store 32'hDEAD_BEEF to BASE+0x00 → PortOut=32'hDEAD_BEEF after that edge; load returns it. Store to BASE+0x04 → PORT_IN unchanged.
- PortIn 8'h00→8'hA5 → PORT_IN=32'hA5 two edges later; IN_EDGE=32'hA5 one edge after that; EdgePending=1 one edge after that. Store 32'h05 to IN_EDGE → IN_EDGE=32'hA0. Rising edge on bit0 in the same cycle as a W1C of bit0 → bit0 stays 1.
- Store 3 to TIMER → reads 2, 1, 0 on successive cycles; STATUS=32'h1 from the cycle the count reaches 0. Store 1 to STATUS → 32'h0. Store 0 to TIMER → DONE stays 0.
- Store 100 to TIMER, assert reset after 10 cycles → TIMER=0, DONE=0, PortOut=0 immediately; no DONE afterwards.
- Store 5 to TIMER with MemRead also high → ReadData shows the old value in that cycle; TIMER=5 the next cycle.
